// File: rtl/orb_sched_pkg.sv
// Shared types for the ORB ping-pong match scheduler: bank and scheduler state encodings.
package orb_sched_pkg;

  localparam int PRA_NUM_BANKS = 2;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } bank_state_e;

  typedef enum logic [2:0] {
    SCH_IDLE,
    SCH_CHECK,
    SCH_OFFER,
    SCH_RUN,
    SCH_RELEASE
  } sched_state_e;

  function automatic logic bank_writable(input bank_state_e s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

endpackage

// File: rtl/orb_bank_tracker.sv
// One ping-pong bank: left/right fill flags, latched feature counts, bank state,
// and the accept/drop decision for frames aimed at this bank.
module orb_bank_tracker
  import orb_sched_pkg::*;
#(
  parameter int PRA_LEN_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [1:0]               i_done,
  input  logic [PRA_LEN_WIDTH-1:0] i_count_0,
  input  logic [PRA_LEN_WIDTH-1:0] i_count_1,
  input  logic                     i_set_reading,
  input  logic                     i_set_empty,
  output bank_state_e              o_state,
  output logic [PRA_LEN_WIDTH-1:0] o_count_0,
  output logic [PRA_LEN_WIDTH-1:0] o_count_1,
  output logic [1:0]               o_drop,
  output logic                     o_to_full
);

  bank_state_e              state_q, state_d;
  logic [1:0]               flag_q, flag_d;
  logic [1:0]               accept;
  logic                     writable;
  logic [PRA_LEN_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    writable  = bank_writable(state_q);
    // A side may write once per fill; FULL/READING banks refuse everything.
    accept    = i_done & ~flag_q & {2{writable}};
    o_drop    = i_done & ~accept;
    flag_d    = flag_q | accept;
    cnt0_d    = accept[0] ? i_count_0 : cnt0_q;
    cnt1_d    = accept[1] ? i_count_1 : cnt1_q;
    state_d   = state_q;
    o_to_full = 1'b0;
    if (writable) begin
      if (&flag_d) begin
        state_d   = BANK_FULL;
        o_to_full = 1'b1;
      end else if (|flag_d) begin
        state_d = BANK_FILLING;
      end
    end
    if (i_set_reading) state_d = BANK_READING;
    if (i_set_empty) begin
      state_d = BANK_EMPTY;
      flag_d  = '0;
      cnt0_d  = '0;
      cnt1_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= BANK_EMPTY;
      flag_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign o_state   = state_q;
  assign o_count_0 = cnt0_q;
  assign o_count_1 = cnt1_q;

endmodule

// File: rtl/orb_match_scheduler.sv
// Ping-pong bank scheduler between the left/right ORB extractors and the matcher.
// Optional watchdog on OFFER/RUN enabled by defining ORB_MATCH_WATCHDOG_EN (adds o_timeout).
module orb_match_scheduler
  import orb_sched_pkg::*;
#(
  parameter int PRA_LEN_WIDTH  = 16,
  parameter int PRA_DROP_WIDTH = 8
`ifdef ORB_MATCH_WATCHDOG_EN
  ,
  parameter int PRA_TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wr_0_frame_done,
  input  logic [PRA_LEN_WIDTH-1:0]  i_wr_0_count,
  output logic                      o_wr_0_bank,
  input  logic                      i_wr_1_frame_done,
  input  logic [PRA_LEN_WIDTH-1:0]  i_wr_1_count,
  output logic                      o_wr_1_bank,
  output logic                      o_orb_0_ready,
  output logic                      o_orb_1_ready,
  input  logic                      i_orb_0_ready_ack,
  input  logic                      i_orb_1_ready_ack,
  output logic [PRA_LEN_WIDTH-1:0]  o_orb_0_valid_length,
  output logic [PRA_LEN_WIDTH-1:0]  o_orb_1_valid_length,
  output logic                      o_rd_bank,
  input  logic                      i_match_end,
  output logic                      o_busy,
  output logic [PRA_DROP_WIDTH-1:0] o_drop_count,
  output logic [PRA_DROP_WIDTH-1:0] o_skip_count,
`ifdef ORB_MATCH_WATCHDOG_EN
  output logic                      o_timeout,
`endif
  output sched_state_e              o_dbg_state
);

  // Handshake: ready stays high with stable lengths until a cycle where both acks
  // are high; that cycle is the transfer and ready falls on the following edge.

  sched_state_e              state_q, state_d;
  logic                      wr_bank_q, wr_bank_d;
  logic                      rd_bank_q, rd_bank_d;
  logic                      age_q, age_d;
  logic                      ready_q, ready_d;
  logic [PRA_LEN_WIDTH-1:0]  len0_q, len0_d, len1_q, len1_d;
  logic [PRA_DROP_WIDTH-1:0] drop_q, drop_d, skip_q, skip_d;
  logic [PRA_DROP_WIDTH:0]   drop_sum;
  logic [1:0]                drop_any;
  logic [1:0]                drop_inc;
  logic                      skip_inc;
  logic                      full_0, full_1;
  logic [PRA_LEN_WIDTH-1:0]  cur_cnt0, cur_cnt1;

  bank_state_e               bank_state [PRA_NUM_BANKS];
  logic [PRA_LEN_WIDTH-1:0]  bank_cnt0  [PRA_NUM_BANKS];
  logic [PRA_LEN_WIDTH-1:0]  bank_cnt1  [PRA_NUM_BANKS];
  logic [1:0]                bank_drop  [PRA_NUM_BANKS];
  logic [PRA_NUM_BANKS-1:0]  bank_to_full;
  logic [PRA_NUM_BANKS-1:0]  set_reading;
  logic [PRA_NUM_BANKS-1:0]  set_empty;

  for (genvar b = 0; b < PRA_NUM_BANKS; b++) begin : g_bank
    logic [1:0] done_hit;
    assign done_hit = {i_wr_1_frame_done, i_wr_0_frame_done} & {2{wr_bank_q == 1'(b)}};

    orb_bank_tracker #(
      .PRA_LEN_WIDTH(PRA_LEN_WIDTH)
    ) u_bank (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_done       (done_hit),
      .i_count_0    (i_wr_0_count),
      .i_count_1    (i_wr_1_count),
      .i_set_reading(set_reading[b]),
      .i_set_empty  (set_empty[b]),
      .o_state      (bank_state[b]),
      .o_count_0    (bank_cnt0[b]),
      .o_count_1    (bank_cnt1[b]),
      .o_drop       (bank_drop[b]),
      .o_to_full    (bank_to_full[b])
    );
  end

`ifdef ORB_MATCH_WATCHDOG_EN
  localparam int WD_W = $clog2(PRA_TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    full_0    = (bank_state[0] == BANK_FULL);
    full_1    = (bank_state[1] == BANK_FULL);
    cur_cnt0  = bank_cnt0[rd_bank_q];
    cur_cnt1  = bank_cnt1[rd_bank_q];
    drop_any  = bank_drop[0] | bank_drop[1];
    drop_inc  = {1'b0, drop_any[0]} + {1'b0, drop_any[1]};
    drop_sum  = {1'b0, drop_q} + (PRA_DROP_WIDTH + 1)'(drop_inc);
    drop_d    = drop_sum[PRA_DROP_WIDTH] ? '1 : drop_sum[PRA_DROP_WIDTH-1:0];

    // Writers move on to the other bank as soon as the current one completes.
    wr_bank_d = wr_bank_q ^ (|bank_to_full);
    // The age bit only moves when the newly full bank has no older FULL rival.
    age_d     = age_q;
    if (bank_to_full[0] && !full_1) age_d = 1'b0;
    if (bank_to_full[1] && !full_0) age_d = 1'b1;

    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    ready_d     = ready_q;
    len0_d      = len0_q;
    len1_d      = len1_q;
    set_reading = '0;
    set_empty   = '0;
    skip_inc    = 1'b0;

    case (state_q)
      SCH_IDLE: begin
        if (full_0 || full_1) begin
          rd_bank_d = (full_0 && full_1) ? age_q : full_1;
          state_d   = SCH_CHECK;
        end
      end
      SCH_CHECK: begin
        if (cur_cnt0 == '0 || cur_cnt1 == '0) begin
          set_empty[rd_bank_q] = 1'b1;
          skip_inc             = 1'b1;
          state_d              = SCH_IDLE;
        end else begin
          len0_d                 = cur_cnt0;
          len1_d                 = cur_cnt1;
          ready_d                = 1'b1;
          set_reading[rd_bank_q] = 1'b1;
          state_d                = SCH_OFFER;
        end
      end
      SCH_OFFER: begin
        if (i_orb_0_ready_ack && i_orb_1_ready_ack) begin
          ready_d = 1'b0;
          state_d = SCH_RUN;
        end
      end
      SCH_RUN: begin
        if (i_match_end) state_d = SCH_RELEASE;
      end
      SCH_RELEASE: begin
        set_empty[rd_bank_q] = 1'b1;
        len0_d               = '0;
        len1_d               = '0;
        state_d              = SCH_IDLE;
      end
      default: state_d = SCH_IDLE;
    endcase

    skip_d = (skip_inc && skip_q != '1) ? skip_q + PRA_DROP_WIDTH'(1) : skip_q;

`ifdef ORB_MATCH_WATCHDOG_EN
    timeout_d = 1'b0;
    wd_d      = '0;
    if (state_q == SCH_OFFER || state_q == SCH_RUN) begin
      wd_d = wd_q + WD_W'(1);
      if (wd_q == WD_W'(PRA_TIMEOUT_CYCLES - 1)) begin
        state_d   = SCH_RELEASE;
        ready_d   = 1'b0;
        timeout_d = 1'b1;
        wd_d      = '0;
      end
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= SCH_IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      age_q     <= 1'b0;
      ready_q   <= 1'b0;
      len0_q    <= '0;
      len1_q    <= '0;
      drop_q    <= '0;
      skip_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      age_q     <= age_d;
      ready_q   <= ready_d;
      len0_q    <= len0_d;
      len1_q    <= len1_d;
      drop_q    <= drop_d;
      skip_q    <= skip_d;
    end
  end

`ifdef ORB_MATCH_WATCHDOG_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_timeout = timeout_q;
`endif

  assign o_wr_0_bank          = wr_bank_q;
  assign o_wr_1_bank          = wr_bank_q;
  assign o_orb_0_ready        = ready_q;
  assign o_orb_1_ready        = ready_q;
  assign o_orb_0_valid_length = len0_q;
  assign o_orb_1_valid_length = len1_q;
  assign o_rd_bank            = rd_bank_q;
  assign o_busy               = (state_q == SCH_OFFER) || (state_q == SCH_RUN);
  assign o_drop_count         = drop_q;
  assign o_skip_count         = skip_q;
  assign o_dbg_state          = state_q;

endmodule
